// File: rtl/mapper_mem_sequencer.sv
// Serialises mapped PRG (CPU) and CHR (PPU) accesses onto one req/ack memory port.
// Optional overrun counters are built when MAPPER_MEMSEQ_STATS_EN is defined.
module mapper_mem_sequencer #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic              prg_rd,
    input  logic              prg_wr,
    input  logic              prg_allow,
    input  logic [DATA_W-1:0] prg_wdata,
    output logic [DATA_W-1:0] prg_rdata,
    output logic              prg_done,
    input  logic [ADDR_W-1:0] chr_addr,
    input  logic              chr_rd,
    input  logic              chr_wr,
    input  logic              chr_allow,
    input  logic [DATA_W-1:0] chr_wdata,
    output logic [DATA_W-1:0] chr_rdata,
    output logic              chr_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MAPPER_MEMSEQ_STATS_EN
    output logic [STAT_W-1:0] prg_ovr_cnt,
    output logic [STAT_W-1:0] chr_ovr_cnt,
`endif
    output logic [1:0]        overrun,
    input  logic              ovr_clr
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Side index 0 = PRG, 1 = CHR throughout.
    logic [1:0]        rd_s, wr_s, allow_rd, allow_wr, load;
    logic [ADDR_W-1:0] addr_in [2];
    logic [DATA_W-1:0] wdata_in [2];

    logic [1:0]        slot_v_q, slot_v_d, slot_we_q;
    logic [ADDR_W-1:0] slot_addr_q [2];
    logic [DATA_W-1:0] slot_wdata_q [2];

    logic [1:0]        cand_v, cand_we, granted, ovr_evt;
    logic [ADDR_W-1:0] cand_addr [2];
    logic [DATA_W-1:0] cand_wdata [2];

    state_t            state_q;
    logic              last_grant_q;
    logic              gnt_en, gnt_side;
    logic [1:0]        overrun_q;

    assign rd_s        = {chr_rd, prg_rd};
    assign wr_s        = {chr_wr, prg_wr};
    assign allow_rd    = {1'b1, prg_allow};
    assign allow_wr    = {chr_allow, prg_allow};
    assign addr_in[0]  = prg_addr;
    assign addr_in[1]  = chr_addr;
    assign wdata_in[0] = prg_wdata;
    assign wdata_in[1] = chr_wdata;

    assign gnt_en   = (state_q == IDLE) && (|cand_v);
    assign gnt_side = (&cand_v) ? ~last_grant_q : cand_v[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            // A write strobe wins over a simultaneous read; the write's permit then decides.
            assign load[gi] = ce & (wr_s[gi] ? allow_wr[gi] : (rd_s[gi] & allow_rd[gi]));

            // An idle grant may take a fresh strobe straight through without parking it.
            assign cand_v[gi]     = slot_v_q[gi] | load[gi];
            assign cand_we[gi]    = slot_v_q[gi] ? slot_we_q[gi]    : wr_s[gi];
            assign cand_addr[gi]  = slot_v_q[gi] ? slot_addr_q[gi]  : addr_in[gi];
            assign cand_wdata[gi] = slot_v_q[gi] ? slot_wdata_q[gi] : wdata_in[gi];

            assign granted[gi]  = gnt_en & (gnt_side == 1'(gi));
            assign slot_v_d[gi] = granted[gi] ? (slot_v_q[gi] & load[gi])
                                              : (slot_v_q[gi] | load[gi]);
            assign ovr_evt[gi]  = load[gi] & slot_v_q[gi] & ~granted[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_v_q[gi]     <= 1'b0;
                    slot_we_q[gi]    <= 1'b0;
                    slot_addr_q[gi]  <= '0;
                    slot_wdata_q[gi] <= '0;
                    overrun_q[gi]    <= 1'b0;
                end else begin
                    slot_v_q[gi] <= slot_v_d[gi];
                    if (load[gi]) begin
                        slot_we_q[gi]    <= wr_s[gi];
                        slot_addr_q[gi]  <= addr_in[gi];
                        slot_wdata_q[gi] <= wdata_in[gi];
                    end
                    if (ovr_evt[gi])
                        overrun_q[gi] <= 1'b1;
                    else if (ovr_clr)
                        overrun_q[gi] <= 1'b0;
                end
            end

`ifdef MAPPER_MEMSEQ_STATS_EN
            logic [STAT_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    cnt_q <= '0;
                else if (ovr_evt[gi])
                    cnt_q <= ovr_clr ? STAT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
                else if (ovr_clr)
                    cnt_q <= '0;
            end
`endif
        end
    endgenerate

`ifdef MAPPER_MEMSEQ_STATS_EN
    assign prg_ovr_cnt = g_side[0].cnt_q;
    assign chr_ovr_cnt = g_side[1].cnt_q;
`endif
    assign overrun = overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            prg_done     <= 1'b0;
            chr_done     <= 1'b0;
            prg_rdata    <= '0;
            chr_rdata    <= '0;
        end else begin
            prg_done <= 1'b0;
            chr_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_en) begin
                        mem_req      <= 1'b1;
                        mem_we       <= cand_we[gnt_side];
                        mem_addr     <= cand_addr[gnt_side];
                        mem_wdata    <= cand_wdata[gnt_side];
                        last_grant_q <= gnt_side;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // No regrant here: the ack cycle is always followed by one idle cycle.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= IDLE;
                        if (last_grant_q) begin
                            chr_done <= 1'b1;
                            if (!mem_we) chr_rdata <= mem_rdata;
                        end else begin
                            prg_done <= 1'b1;
                            if (!mem_we) prg_rdata <= mem_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
